// File: rtl/moving_average_var_window.sv
// rtl/moving_average_var_window.sv - run-time selectable 2^p moving-average filter with flush on window change
// Optional: define MOVING_AVERAGE_ROUNDING_EN for round-half-up output instead of truncation.
module moving_average_var_window #(
  parameter int DATA_W    = 10,
  parameter int MAX_POWER = 4,
  parameter int SEL_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe_in,
  input  logic [SEL_W-1:0]  win_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              window_full,
  output logic              busy
);
  localparam int DEPTH = 1 << MAX_POWER;
  localparam int SUM_W = DATA_W + MAX_POWER;
  localparam int CNT_W = MAX_POWER + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [DATA_W-1:0]      sample_buf [DEPTH];
  logic [MAX_POWER-1:0]   clr_idx, wr_ptr, rd_idx;
  logic [SUM_W-1:0]       sum, sum_next;
  logic [CNT_W-1:0]       fill_cnt, fill_next, win_len;
  logic [SEL_W-1:0]       p_act, p_req;
  logic [DATA_W-1:0]      old_sample, avg;
  logic                   accept;

  always_comb begin
    p_req      = (win_sel > SEL_W'(MAX_POWER)) ? SEL_W'(MAX_POWER) : win_sel;
    win_len    = CNT_W'(1) << p_act;
    // For the largest window the low bits of win_len are zero, so the oldest slot is wr_ptr itself
    rd_idx     = wr_ptr - win_len[MAX_POWER-1:0];
    old_sample = sample_buf[rd_idx];
    sum_next   = sum + SUM_W'(data_in) - SUM_W'(old_sample);
    fill_next  = (fill_cnt == win_len) ? fill_cnt : fill_cnt + CNT_W'(1);
    accept     = (state == RUN) && strobe_in && (p_req == p_act);
  end

`ifdef MOVING_AVERAGE_ROUNDING_EN
  always_comb avg = DATA_W'(({1'b0, sum_next} + (((SUM_W+1)'(1) << p_act) >> 1)) >> p_act);
`else
  always_comb avg = DATA_W'(sum_next >> p_act);
`endif

  // Sample storage carries no reset; the CLEAR sweep zeroes it after every reset or window change
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      sample_buf[clr_idx] <= '0;
    else if (accept)
      sample_buf[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      wr_ptr      <= '0;
      sum         <= '0;
      fill_cnt    <= '0;
      p_act       <= '0;
      data_out    <= '0;
      strobe_out  <= 1'b0;
      window_full <= 1'b0;
      busy        <= 1'b1;
    end else begin
      strobe_out <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx     <= clr_idx + MAX_POWER'(1);
          wr_ptr      <= '0;
          sum         <= '0;
          fill_cnt    <= '0;
          window_full <= 1'b0;
          busy        <= 1'b1;
          if (clr_idx == MAX_POWER'(DEPTH-1)) begin
            p_act <= p_req;
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (p_req != p_act) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            window_full <= 1'b0;
          end else if (strobe_in) begin
            wr_ptr      <= wr_ptr + MAX_POWER'(1);
            sum         <= sum_next;
            data_out    <= avg;
            strobe_out  <= 1'b1;
            fill_cnt    <= fill_next;
            window_full <= (fill_next == win_len);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_moving_average_var_window.sv
// tb/tb_moving_average_var_window.sv - directed self-checking bench for moving_average_var_window
module tb_moving_average_var_window;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data_in;
  logic       strobe_in;
  logic [2:0] win_sel;
  logic [9:0] data_out;
  logic       strobe_out;
  logic       window_full;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MOVING_AVERAGE_ROUNDING_EN
  localparam int RND16 = 8;
`else
  localparam int RND16 = 0;
`endif

  moving_average_var_window dut (
    .clk(clk), .reset(reset), .data_in(data_in), .strobe_in(strobe_in), .win_sel(win_sel),
    .data_out(data_out), .strobe_out(strobe_out), .window_full(window_full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] d, input int exp, input string tag);
    data_in   = d;
    strobe_in = 1'b1;
    step();
    strobe_in = 1'b0;
    chk({tag, "_stb"}, 32'(strobe_out), 1);
    chk(tag, 32'(data_out), exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 32'(data_out), 0);
    chk({tag, "_stb"}, 32'(strobe_out), 0);
    chk({tag, "_full"}, 32'(window_full), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Counts CLEAR cycles until busy drops (bounded) and any stray strobe_out seen meanwhile
  task automatic wait_flush(input string tag);
    int cnt  = 0;
    int seen = 0;
    while (busy && cnt < 40) begin
      step();
      cnt++;
      if (strobe_out) seen++;
    end
    strobe_in = 1'b0;
    chk({tag, "_len"}, 32'(cnt), 16);
    chk({tag, "_nostb"}, 32'(seen), 0);
  endtask

  initial begin
    reset = 1'b1; data_in = '0; strobe_in = 1'b0; win_sel = 3'd2;
    step(); step();
    chk_reset_vals("por");
    reset = 1'b0;
    wait_flush("flush_p2");

    push(10'd100, 25, "p2_s1");
    push(10'd200, 75, "p2_s2");
    push(10'd300, 150, "p2_s3");
    chk("p2_full3", 32'(window_full), 0);
    push(10'd400, 250, "p2_s4");
    chk("p2_full4", 32'(window_full), 1);
    push(10'd500, 350, "p2_s5");
    push(10'd500, 425, "p2_s6");
    step();
    chk("p2_pulse", 32'(strobe_out), 0);
    chk("p2_hold", 32'(data_out), 425);

    win_sel = 3'd4;
    step();
    chk("to4_busy", 32'(busy), 1);
    wait_flush("flush_p4");
    for (int k = 1; k <= 20; k++) begin
      push(10'd1023, (k > 16) ? 1023 : (1023 * k + RND16) / 16, $sformatf("ramp_%0d", k));
      chk($sformatf("ramp_full_%0d", k), 32'(window_full), (k >= 16) ? 1 : 0);
    end

    win_sel = 3'd1; data_in = 10'd5; strobe_in = 1'b1;
    step();
    strobe_in = 1'b0;
    chk("chg_nostb", 32'(strobe_out), 0);
    chk("chg_busy", 32'(busy), 1);
    chk("chg_full", 32'(window_full), 0);
    chk("chg_hold", 32'(data_out), 1023);
    wait_flush("flush_p1");
    push(10'd10, 5, "p1_s1");
    push(10'd30, 20, "p1_s2");

    win_sel = 3'd0;
    step();
    wait_flush("flush_p0");
    push(10'd7, 7, "p0_s1");
    push(10'd8, 8, "p0_s2");
    push(10'd9, 9, "p0_s3");
    chk("p0_full", 32'(window_full), 1);

    win_sel = 3'd7;
    step();
    wait_flush("flush_clamp");
    push(10'd16, 1, "clamp_s1");
    chk("clamp_full", 32'(window_full), 0);

    reset = 1'b1;
    #1;
    chk_reset_vals("rst_run");
    step();
    reset = 1'b0;
    wait_flush("flush_rst_run");

    push(10'd48, 3, "post_rst_s1");
    reset = 1'b1;
    step();
    reset = 1'b0;
    strobe_in = 1'b1; data_in = 10'd300;
    repeat (5) begin
      step();
      chk("clr_nostb", 32'(strobe_out), 0);
    end
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_clr");
    step();
    reset = 1'b0;
    wait_flush("flush_rst_clr");
    push(10'd32, 2, "final_s1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
